// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, fixed ordered-set words and the transmit FSM state type.
package xgmii_pkg;

  localparam logic [7:0] CH_IDLE     = 8'h07;
  localparam logic [7:0] CH_START    = 8'hFB;
  localparam logic [7:0] CH_TERM     = 8'hFD;
  localparam logic [7:0] CH_ERROR    = 8'hFE;
  localparam logic [7:0] CH_SEQ      = 8'h9C;
  localparam logic [7:0] CH_PREAMBLE = 8'h55;
  localparam logic [7:0] CH_SFD      = 8'hD5;

  localparam logic [63:0] WORD_IDLE  = {8{CH_IDLE}};
  localparam logic [63:0] WORD_ERROR = {8{CH_ERROR}};
  localparam logic [63:0] WORD_START = {CH_SFD, {6{CH_PREAMBLE}}, CH_START};
  localparam logic [63:0] WORD_TERM  = {{7{CH_IDLE}}, CH_TERM};
  // Sequence ordered sets: 0x9C in lanes 0 and 4, fault code in lanes 3 and 7.
  localparam logic [63:0] WORD_RF    = {2{8'h02, 8'h00, 8'h00, CH_SEQ}};
  localparam logic [63:0] WORD_LF    = {2{8'h01, 8'h00, 8'h00, CH_SEQ}};

  localparam logic [7:0] TXC_ALL   = 8'hFF;
  localparam logic [7:0] TXC_NONE  = 8'h00;
  localparam logic [7:0] TXC_START = 8'h01;
  localparam logic [7:0] TXC_SEQ   = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TERM,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/xgmii_term_encoder.sv
// Builds the end-of-frame XGMII word for 1..7 valid bytes: data, /T/, then idles.
module xgmii_term_encoder
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  bytes,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    localparam logic [2:0] LANE = 3'(gi);
    assign txc[gi]         = !(LANE < bytes);
    assign txd[8*gi +: 8]  = (LANE < bytes)  ? data[8*gi +: 8] :
                             (LANE == bytes) ? CH_TERM : CH_IDLE;
  end

endmodule

// File: rtl/xgmii_rs_tx.sv
// Transmit reconciliation sublayer: frames a 64-bit word stream into XGMII and
// handles link fault signalling.
module xgmii_rs_tx
  import xgmii_pkg::*;
#(
  parameter int IFG_CYCLES = 2,
  parameter int FAULT_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_start,
  input  logic        tx_end,
  input  logic [2:0]  tx_bytes,
  output logic        tx_ready,
  input  logic        local_fault,
  input  logic        remote_fault,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        tx_underrun,
  output logic        tx_dropped
);

  localparam int HOLD_W = $clog2(FAULT_HOLD + 1);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);

  tx_state_t        state_reg;
  logic [IFG_W-1:0] ifg_cnt_reg;
  logic [63:0]      txd_reg;
  logic [7:0]       txc_reg;
  logic             underrun_reg;

  logic [1:0]  fault_in;
  logic [1:0]  fault_reg;   // bit 0 = local, bit 1 = remote
  logic [63:0] term_txd;
  logic [7:0]  term_txc;
  logic        idle_drop;

  assign fault_in = {remote_fault, local_fault};

  // A fault sets immediately and clears only after FAULT_HOLD quiet cycles.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fault
    logic              flt_reg;
    logic [HOLD_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        flt_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (fault_in[gi]) begin
        flt_reg <= 1'b1;
        cnt_reg <= '0;
      end else if (flt_reg) begin
        if (cnt_reg == HOLD_W'(FAULT_HOLD - 1)) begin
          flt_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign fault_reg[gi] = flt_reg;
  end

  xgmii_term_encoder u_term_encoder (
    .data  (tx_data),
    .bytes (tx_bytes),
    .txd   (term_txd),
    .txc   (term_txc)
  );

  // The handshake is decided from registered state plus this cycle's word:
  // in IDLE only stray non-start words are pulled (and thrown away).
  assign idle_drop  = !fault_reg[0] && !fault_reg[1] && tx_valid && !tx_start;
  assign tx_ready   = !reset && ((state_reg == ST_DATA) ||
                                 (state_reg == ST_IDLE && idle_drop));
  assign tx_dropped = !reset && (state_reg == ST_IDLE) && idle_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      ifg_cnt_reg  <= '0;
      txd_reg      <= WORD_IDLE;
      txc_reg      <= TXC_ALL;
      underrun_reg <= 1'b0;
    end else begin
      txd_reg      <= WORD_IDLE;
      txc_reg      <= TXC_ALL;
      underrun_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fault_reg[0]) begin
            txd_reg <= WORD_RF;
            txc_reg <= TXC_SEQ;
          end else if (!fault_reg[1] && tx_valid && tx_start) begin
            // Start word is emitted without consuming the first frame word.
            txd_reg   <= WORD_START;
            txc_reg   <= TXC_START;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!tx_valid) begin
            txd_reg      <= WORD_ERROR;
            underrun_reg <= 1'b1;
            ifg_cnt_reg  <= IFG_W'(IFG_CYCLES);
            state_reg    <= ST_IFG;
          end else if (tx_end && tx_bytes != 3'd0) begin
            txd_reg     <= term_txd;
            txc_reg     <= term_txc;
            ifg_cnt_reg <= IFG_W'(IFG_CYCLES);
            state_reg   <= ST_IFG;
          end else begin
            txd_reg <= tx_data;
            txc_reg <= TXC_NONE;
            if (tx_end) begin
              state_reg <= ST_TERM;
            end
          end
        end
        ST_TERM: begin
          txd_reg     <= WORD_TERM;
          ifg_cnt_reg <= IFG_W'(IFG_CYCLES);
          state_reg   <= ST_IFG;
        end
        ST_IFG: begin
          if (ifg_cnt_reg <= IFG_W'(1)) begin
            ifg_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            ifg_cnt_reg <= ifg_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign xgmii_txd   = txd_reg;
  assign xgmii_txc   = txc_reg;
  assign tx_underrun = underrun_reg;

endmodule
